// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA raster generator: default 640x480@60 timing,
// counter/colour widths and the packed colour layout.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(cnt) >= lo) && (32'(cnt) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_counter.sv
// Pixel-enable divider and horizontal/vertical raster counters.
module vga_timing_gen_sync_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             tick,
  output logic             video_on
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  // With CLK_DIV=1 the divider stays at 0 and tick is permanently high.
  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign video_on = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: counters plus registered sync, colour and frame_start,
// all launched on the pixel tick so sync and colour stay aligned.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      rgb,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             frame_start,
  output logic             h_sync,
  output logic             v_sync,
  output logic [3:0]       Red,
  output logic [3:0]       Green,
  output logic [3:0]       Blue
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC - 1;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC - 1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             tick;
  logic             h_win;
  logic             v_win;
  rgb_t             colour_q;

  vga_timing_gen_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_TOTAL (H_TOTAL),
    .V_ACTIVE(V_ACTIVE),
    .V_TOTAL (V_TOTAL)
  ) u_sync_counter (
    .clk     (clk),
    .rst     (rst),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .tick    (tick),
    .video_on(video_on)
  );

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
  assign h_win   = in_window(h_cnt, H_SYNC_LO, H_SYNC_HI);
  assign v_win   = in_window(v_cnt, V_SYNC_LO, V_SYNC_HI);
  assign Red     = colour_q.r;
  assign Green   = colour_q.g;
  assign Blue    = colour_q.b;

  // Everything below samples the counter values present before the tick's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      colour_q    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        h_sync   <= h_win ? SYNC_POL : ~SYNC_POL;
        v_sync   <= v_win ? SYNC_POL : ~SYNC_POL;
        colour_q <= video_on ? rgb_t'(rgb) : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-timing instances for full-frame checks, plus the
// default 640x480 instance for one line of real timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: CLK_DIV=2, H_TOTAL=15 (sync 10..12), V_TOTAL=8 (sync 5..6), active-low
  logic        rst_a;
  logic [11:0] rgb_a;
  logic [9:0]  x_a, y_a;
  logic        von_a, fs_a, hs_a, vs_a;
  logic [3:0]  r_a, g_a, b_a;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst_a), .rgb(rgb_a), .pixel_x(x_a), .pixel_y(y_a),
    .video_on(von_a), .frame_start(fs_a), .h_sync(hs_a), .v_sync(vs_a),
    .Red(r_a), .Green(g_a), .Blue(b_a)
  );

  // Instance B: same raster, CLK_DIV=1 and active-high syncs
  logic        rst_b;
  logic [11:0] rgb_b;
  logic [9:0]  x_b, y_b;
  logic        von_b, fs_b, hs_b, vs_b;
  logic [3:0]  r_b, g_b, b_b;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst_b), .rgb(rgb_b), .pixel_x(x_b), .pixel_y(y_b),
    .video_on(von_b), .frame_start(fs_b), .h_sync(hs_b), .v_sync(vs_b),
    .Red(r_b), .Green(g_b), .Blue(b_b)
  );

  // Instance D: default 640x480 timing
  logic        rst_d;
  logic [11:0] rgb_d;
  logic [9:0]  x_d, y_d;
  logic        von_d, fs_d, hs_d, vs_d;
  logic [3:0]  r_d, g_d, b_d;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst_d), .rgb(rgb_d), .pixel_x(x_d), .pixel_y(y_d),
    .video_on(von_d), .frame_start(fs_d), .h_sync(hs_d), .v_sync(vs_d),
    .Red(r_d), .Green(g_d), .Blue(b_d)
  );

  typedef struct {
    int unsigned edge_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        fs;
    logic [11:0] col;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int unsigned e, input logic [9:0] x, input logic [9:0] y,
                     input logic hs, input logic vs, input logic von, input logic fs,
                     input logic [11:0] col);
    vec_t v;
    v.edge_n = e; v.x = x; v.y = y; v.hs = hs; v.vs = vs;
    v.von = von; v.fs = fs; v.col = col;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned ea;
    bit found;
    logic [11:0] prev;
    logic [11:0] good [5];
    logic [11:0] junk [5];
    int fs_count, fs_bad;
    logic fs_prev;
    int hs_rise1, hs_rise2, hs_fall1, vs_rise1, vs_fall1;
    logic hs_p, vs_p;
    int d_fall1, d_rise1, d_fall2;

    rst_a = 1'b1; rst_b = 1'b1; rst_d = 1'b1;
    rgb_a = 12'hF0A; rgb_b = 12'h3C5; rgb_d = 12'hF0A;

    // Edge n = n-th clock edge after rst_a falls; ticks on even edges.
    add(0,   0, 0, 1, 1, 1, 0, 12'h000);
    add(1,   0, 0, 1, 1, 1, 0, 12'h000);
    add(2,   1, 0, 1, 1, 1, 1, 12'hF0A);
    add(3,   1, 0, 1, 1, 1, 0, 12'hF0A);
    add(16,  8, 0, 1, 1, 0, 0, 12'hF0A);
    add(18,  9, 0, 1, 1, 0, 0, 12'h000);
    add(20, 10, 0, 1, 1, 0, 0, 12'h000);
    add(22, 11, 0, 0, 1, 0, 0, 12'h000);
    add(26, 13, 0, 0, 1, 0, 0, 12'h000);
    add(28, 14, 0, 1, 1, 0, 0, 12'h000);
    add(30,  0, 1, 1, 1, 1, 0, 12'h000);
    add(32,  1, 1, 1, 1, 1, 0, 12'hF0A);
    add(106, 8, 3, 1, 1, 0, 0, 12'hF0A);
    add(120, 0, 4, 1, 1, 0, 0, 12'h000);
    add(122, 1, 4, 1, 1, 0, 0, 12'h000);
    add(150, 0, 5, 1, 1, 0, 0, 12'h000);
    add(152, 1, 5, 1, 0, 0, 0, 12'h000);
    add(210, 0, 7, 1, 0, 1 & 1'b0, 0, 12'h000);
    add(212, 1, 7, 1, 1, 0, 0, 12'h000);
    add(240, 0, 0, 1, 1, 1, 0, 12'h000);
    add(242, 1, 0, 1, 1, 1, 1, 12'hF0A);
    add(243, 1, 0, 1, 1, 1, 0, 12'hF0A);

    step(2);
    rst_a = 1'b0;
    ea = 0;
    foreach (vecs[i]) begin
      while (ea < vecs[i].edge_n) begin
        step(1);
        ea++;
      end
      chk($sformatf("v%0d.x", i),   x_a,   vecs[i].x);
      chk($sformatf("v%0d.y", i),   y_a,   vecs[i].y);
      chk($sformatf("v%0d.hs", i),  hs_a,  vecs[i].hs);
      chk($sformatf("v%0d.vs", i),  vs_a,  vecs[i].vs);
      chk($sformatf("v%0d.von", i), von_a, vecs[i].von);
      chk($sformatf("v%0d.fs", i),  fs_a,  vecs[i].fs);
      chk($sformatf("v%0d.col", i), {r_a, g_a, b_a}, vecs[i].col);
    end

    // Three frames: pulses at edges 482, 722, 962, each one clk wide at (1,0).
    fs_count = 0; fs_bad = 0; fs_prev = fs_a;
    for (int i = 0; i < 720; i++) begin
      step(1);
      if (fs_a) begin
        fs_count++;
        if (fs_prev || x_a != 10'd1 || y_a != 10'd0) fs_bad++;
      end
      fs_prev = fs_a;
    end
    chk("fs_count", fs_count, 3);
    chk("fs_shape", fs_bad, 0);

    // Mid-frame reset while both syncs are asserted.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (x_a == 10'd11 && y_a == 10'd5) found = 1'b1;
      else step(1);
    end
    chk("mid_reach", found, 1'b1);
    chk("mid_pre_hs", hs_a, 1'b0);
    chk("mid_pre_vs", vs_a, 1'b0);
    rst_a = 1'b1;
    step(1);
    chk("mid_rst_x", x_a, 0);
    chk("mid_rst_y", y_a, 0);
    chk("mid_rst_hs", hs_a, 1'b1);
    chk("mid_rst_vs", vs_a, 1'b1);
    chk("mid_rst_col", {r_a, g_a, b_a}, 12'h000);
    chk("mid_rst_fs", fs_a, 1'b0);
    rst_a = 1'b0;
    step(1);
    chk("mid_e1_x", x_a, 0);
    step(1);
    chk("mid_e2_x", x_a, 1);
    chk("mid_e2_fs", fs_a, 1'b1);

    // rgb changes on non-tick edges must not reach the outputs.
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    good[0] = 12'h5A5; good[1] = 12'h0C3; good[2] = 12'hF00; good[3] = 12'h00F; good[4] = 12'h9E1;
    junk[0] = 12'h123; junk[1] = 12'hFFF; junk[2] = 12'hABC; junk[3] = 12'h777; junk[4] = 12'hE0E;
    prev = 12'h000;
    for (int k = 0; k < 5; k++) begin
      rgb_a = junk[k];
      step(1);
      chk($sformatf("tog%0d.hold", k), {r_a, g_a, b_a}, prev);
      rgb_a = good[k];
      step(1);
      chk($sformatf("tog%0d.take", k), {r_a, g_a, b_a}, good[k]);
      prev = good[k];
    end

    // CLK_DIV=1, active-high syncs.
    chk("b_rst_hs", hs_b, 1'b0);
    chk("b_rst_vs", vs_b, 1'b0);
    rst_b = 1'b0;
    step(1);
    chk("b_e1_x", x_b, 1);
    chk("b_e1_fs", fs_b, 1'b1);
    chk("b_e1_von", von_b, 1'b1);
    chk("b_e1_col", {r_b, g_b, b_b}, 12'h3C5);
    step(1);
    chk("b_e2_x", x_b, 2);
    chk("b_e2_y", y_b, 0);
    hs_rise1 = -1; hs_rise2 = -1; hs_fall1 = -1; vs_rise1 = -1; vs_fall1 = -1;
    hs_p = hs_b; vs_p = vs_b;
    for (int e = 3; e <= 300; e++) begin
      step(1);
      if (hs_b && !hs_p) begin
        if (hs_rise1 < 0) hs_rise1 = e;
        else if (hs_rise2 < 0) hs_rise2 = e;
      end
      if (!hs_b && hs_p && hs_fall1 < 0) hs_fall1 = e;
      if (vs_b && !vs_p && vs_rise1 < 0) vs_rise1 = e;
      if (!vs_b && vs_p && vs_fall1 < 0) vs_fall1 = e;
      hs_p = hs_b; vs_p = vs_b;
    end
    chk("b_hs_rise", hs_rise1, 11);
    chk("b_hs_width", hs_fall1 - hs_rise1, 3);
    chk("b_hs_period", hs_rise2 - hs_rise1, 15);
    chk("b_vs_rise", vs_rise1, 76);
    chk("b_vs_width", vs_fall1 - vs_rise1, 30);

    // Default timing: one line and a bit.
    chk("d_rst_hs", hs_d, 1'b1);
    rst_d = 1'b0;
    d_fall1 = -1; d_rise1 = -1; d_fall2 = -1;
    hs_p = hs_d;
    for (int e = 1; e <= 6000; e++) begin
      step(1);
      if (e == 3) chk("d_e3_x", x_d, 0);
      if (e == 4) begin
        chk("d_e4_x", x_d, 1);
        chk("d_e4_col", {r_d, g_d, b_d}, 12'hF0A);
        chk("d_e4_fs", fs_d, 1'b1);
        chk("d_e4_von", von_d, 1'b1);
        chk("d_e4_vs", vs_d, 1'b1);
      end
      if (e == 2563) chk("d_x639_col", {r_d, g_d, b_d}, 12'hF0A);
      if (e == 2564) begin
        chk("d_x640_col", {r_d, g_d, b_d}, 12'h000);
        chk("d_x641_von", von_d, 1'b0);
      end
      if (e == 3200) begin
        chk("d_wrap_x", x_d, 0);
        chk("d_wrap_y", y_d, 1);
      end
      if (!hs_d && hs_p) begin
        if (d_fall1 < 0) d_fall1 = e;
        else if (d_fall2 < 0) d_fall2 = e;
      end
      if (hs_d && !hs_p && d_rise1 < 0) d_rise1 = e;
      hs_p = hs_d;
    end
    chk("d_hs_fall", d_fall1, 2628);
    chk("d_hs_width", d_rise1 - d_fall1, 384);
    chk("d_hs_period", d_fall2 - d_fall1, 3200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
